// File: rtl/memory_read_ctrl.sv
// memory_read_ctrl: egress frame reader for the shared packet buffer.
// Follows a linked list of 64-byte blocks (56 payload bytes + 8-byte footer)
// from a head index, streams the payload one byte per beat with begin/end
// markers, and hands each block back to the free list once it is captured.
// Optional build macro: MEM_READ_PREFETCH_EN adds a second block buffer so the
// next block is read and the current block freed while streaming continues.
module memory_read_ctrl #(
  parameter int ADDR_W        = 10,
  parameter int BLOCK_BITS    = 512,
  parameter int PAYLOAD_BYTES = 56
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  head_valid_i,
  input  logic [ADDR_W-1:0]     head_idx_i,
  output logic                  head_ready_o,
  input  logic                  mem_ready_i,
  output logic                  mem_re_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic [7:0]            data_o,
  output logic                  data_valid_o,
  output logic                  data_begin_o,
  output logic                  data_end_o,
  input  logic                  data_ready_i,
  output logic                  fl_free_req_o,
  output logic [ADDR_W-1:0]     fl_free_idx_o,
  input  logic                  fl_free_gnt_i,
  output logic                  err_o
);

  localparam int PAY_W = BLOCK_BITS - 64;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, STREAM, FREE} state_t;

  state_t            state, state_next;
  logic [PAY_W-1:0]  payload;
  logic [ADDR_W-1:0] curr_idx, next_idx;
  logic [5:0]        limit, byte_cnt;
  logic              eop, first, abort, err;
  logic              accept, last_beat, rd_bad;
  logic [5:0]        rd_limit;
  logic              unused_footer;

  // A footer is bad when its valid bit is clear or an eop block carries a
  // byte count outside 1..PAYLOAD_BYTES.
  function automatic logic footer_bad(input logic [63:0] f);
    return !f[63] || (f[62] && (f[61:56] == 6'd0 || f[61:56] > 6'(PAYLOAD_BYTES)));
  endfunction

  function automatic logic [5:0] footer_limit(input logic [63:0] f);
    return f[62] ? f[61:56] : 6'(PAYLOAD_BYTES);
  endfunction

  assign rd_bad        = footer_bad(mem_rdata_i[63:0]);
  assign rd_limit      = footer_limit(mem_rdata_i[63:0]);
  assign unused_footer = ^mem_rdata_i[55:ADDR_W];
  assign accept        = (state == STREAM) && data_ready_i;
  assign last_beat     = accept && (byte_cnt == limit - 6'd1);

`ifdef MEM_READ_PREFETCH_EN
  typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_WAIT, PF_FULL} pf_state_t;

  pf_state_t        pf_state;
  logic [PAY_W-1:0] sh_payload;
  logic [63:0]      sh_footer;
  logic             free_pend, free_done, load_shadow, sh_bad;
  logic             unused_shadow;

  assign sh_bad        = footer_bad(sh_footer);
  assign free_done     = !free_pend || fl_free_gnt_i;
  assign unused_shadow = ^sh_footer[55:ADDR_W];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decision for the block walk.
  always_comb begin
    state_next = state;
`ifdef MEM_READ_PREFETCH_EN
    load_shadow = 1'b0;
`endif
    case (state)
      IDLE:    if (head_valid_i) state_next = RD_REQ;
      RD_REQ:  if (mem_ready_i) state_next = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) state_next = rd_bad ? FREE : STREAM;
`ifdef MEM_READ_PREFETCH_EN
      STREAM: begin
        if (last_beat) begin
          if (!eop && pf_state == PF_FULL && free_done) begin
            load_shadow = 1'b1;
            state_next  = sh_bad ? FREE : STREAM;
          end else begin
            state_next = FREE;
          end
        end
      end
      FREE: begin
        if (free_done) begin
          if (eop || abort) begin
            state_next = IDLE;
          end else if (pf_state == PF_FULL) begin
            load_shadow = 1'b1;
            state_next  = sh_bad ? FREE : STREAM;
          end
        end
      end
`else
      STREAM:  if (last_beat) state_next = FREE;
      FREE:    if (fl_free_gnt_i) state_next = (eop || abort) ? IDLE : RD_REQ;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Block data path: capture, byte shifting, index chaining and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload  <= '0;
      curr_idx <= '0;
      next_idx <= '0;
      limit    <= '0;
      byte_cnt <= '0;
      eop      <= 1'b0;
      first    <= 1'b0;
      abort    <= 1'b0;
      err      <= 1'b0;
`ifdef MEM_READ_PREFETCH_EN
      pf_state   <= PF_IDLE;
      sh_payload <= '0;
      sh_footer  <= '0;
      free_pend  <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (head_valid_i) begin
            curr_idx <= head_idx_i;
            first    <= 1'b1;
            abort    <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            payload  <= mem_rdata_i[BLOCK_BITS-1:64];
            next_idx <= mem_rdata_i[ADDR_W-1:0];
            eop      <= mem_rdata_i[62];
            limit    <= rd_limit;
            byte_cnt <= '0;
            if (rd_bad) begin
              err   <= 1'b1;
              abort <= 1'b1;
            end
`ifdef MEM_READ_PREFETCH_EN
            free_pend <= 1'b1;
            if (!rd_bad && !mem_rdata_i[62]) pf_state <= PF_REQ;
`endif
          end
        end
        STREAM: begin
          if (accept) begin
            payload  <= {payload[PAY_W-9:0], 8'h00};
            byte_cnt <= byte_cnt + 6'd1;
            first    <= 1'b0;
          end
        end
`ifndef MEM_READ_PREFETCH_EN
        FREE: begin
          if (fl_free_gnt_i && !(eop || abort)) curr_idx <= next_idx;
        end
`endif
        default: ;
      endcase
`ifdef MEM_READ_PREFETCH_EN
      if ((state == STREAM || state == FREE) && free_pend && fl_free_gnt_i)
        free_pend <= 1'b0;
      case (pf_state)
        PF_REQ:  if (mem_ready_i) pf_state <= PF_WAIT;
        PF_WAIT: begin
          if (mem_rvalid_i) begin
            sh_payload <= mem_rdata_i[BLOCK_BITS-1:64];
            sh_footer  <= mem_rdata_i[63:0];
            pf_state   <= PF_FULL;
          end
        end
        default: ;
      endcase
      if (load_shadow) begin
        payload   <= sh_payload;
        curr_idx  <= next_idx;
        next_idx  <= sh_footer[ADDR_W-1:0];
        eop       <= sh_footer[62];
        limit     <= footer_limit(sh_footer);
        byte_cnt  <= '0;
        free_pend <= 1'b1;
        if (sh_bad) begin
          err      <= 1'b1;
          abort    <= 1'b1;
          pf_state <= PF_IDLE;
        end else begin
          pf_state <= sh_footer[62] ? PF_IDLE : PF_REQ;
        end
      end
      if (state_next == IDLE) pf_state <= PF_IDLE;
`endif
    end
  end

  assign head_ready_o  = (state == IDLE) && rst_n;
  assign data_valid_o  = (state == STREAM);
  assign data_o        = data_valid_o ? payload[PAY_W-1 -: 8] : 8'h00;
  assign data_begin_o  = data_valid_o && first;
  assign data_end_o    = data_valid_o && eop && (byte_cnt == limit - 6'd1);
  assign err_o         = err;

`ifdef MEM_READ_PREFETCH_EN
  assign mem_re_o      = (state == RD_REQ) || (pf_state == PF_REQ);
  assign mem_addr_o    = (state == RD_REQ) ? curr_idx :
                         (pf_state == PF_REQ) ? next_idx : '0;
  assign fl_free_req_o = (state == STREAM || state == FREE) && free_pend;
`else
  assign mem_re_o      = (state == RD_REQ);
  assign mem_addr_o    = mem_re_o ? curr_idx : '0;
  assign fl_free_req_o = (state == FREE);
`endif
  assign fl_free_idx_o = fl_free_req_o ? curr_idx : '0;

endmodule
